// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle controller: opcode values, FSM state
// encoding, ALU/PC/register-destination selects and the decoder payload.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned ALUOP_W  = 3;

  localparam logic [OPCODE_W-1:0] OP_ADD   = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_SUB   = 6'b000001;
  localparam logic [OPCODE_W-1:0] OP_AND   = 6'b010001;
  localparam logic [OPCODE_W-1:0] OP_OR    = 6'b010011;
  localparam logic [OPCODE_W-1:0] OP_SLL   = 6'b011000;
  localparam logic [OPCODE_W-1:0] OP_ADDIU = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b010000;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b010010;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b011100;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b100110;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100111;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b110000;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b110001;
  localparam logic [OPCODE_W-1:0] OP_BLTZ  = 6'b110010;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b111000;
  localparam logic [OPCODE_W-1:0] OP_JR    = 6'b111001;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 6'b111010;
  localparam logic [OPCODE_W-1:0] OP_HALT  = 6'b111111;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b101
  } state_t;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_SLL = 3'b010,
    ALU_OR  = 3'b011,
    ALU_AND = 3'b100,
    ALU_SLT = 3'b101
  } aluop_t;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JR     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  // Decoder payload: datapath selects plus instruction-class flags.
  typedef struct packed {
    aluop_t     alu_op;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       ext_sel;
    logic [1:0] reg_dst;
    logic       db_data_src;
    logic       wr_reg_d_src;
    logic       is_rtype;
    logic       is_imm;
    logic       is_lw;
    logic       is_sw;
    logic       is_branch;
    logic       is_beq;
    logic       is_bne;
    logic       is_bltz;
    logic       is_j;
    logic       is_jr;
    logic       is_jal;
    logic       is_halt;
  } decode_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Controller <-> instruction register / datapath bundle.
// master: controller side (takes OpCode/zero/sign, drives enables and selects).
// slave : datapath side.
interface multicycle_control_unit_if #(
  parameter int unsigned CNT_W = 32
);
  import cpu_pkg::*;

  logic [OPCODE_W-1:0] OpCode;
  logic                zero;
  logic                sign;
  logic                PCWre;
  logic                IRWre;
  logic                RegWre;
  logic                InsMemRW;
  logic                RD;
  logic                WR;
  logic                ALUSrcA;
  logic                ALUSrcB;
  logic                ExtSel;
  logic                DBDataSrc;
  logic                WrRegDSrc;
  logic [1:0]          RegDst;
  logic [1:0]          PCSrc;
  logic [ALUOP_W-1:0]  ALUOp;
  logic [2:0]          State;
  logic                Halted;
  logic [CNT_W-1:0]    InstrCount;

  modport master (
    input  OpCode, zero, sign,
    output PCWre, IRWre, RegWre, InsMemRW, RD, WR, ALUSrcA, ALUSrcB, ExtSel,
           DBDataSrc, WrRegDSrc, RegDst, PCSrc, ALUOp, State, Halted, InstrCount
  );

  modport slave (
    output OpCode, zero, sign,
    input  PCWre, IRWre, RegWre, InsMemRW, RD, WR, ALUSrcA, ALUSrcB, ExtSel,
           DBDataSrc, WrRegDSrc, RegDst, PCSrc, ALUOp, State, Halted, InstrCount
  );

endinterface

// File: rtl/multicycle_control_unit_decoder.sv
// opcode_decoder: purely combinational OpCode -> datapath selects and
// instruction-class flags. Ports: op (opcode in), dec (decode_t out).
module opcode_decoder
  import cpu_pkg::*;
(
  input  logic [OPCODE_W-1:0] op,
  output decode_t             dec
);

  always_comb begin
    dec              = '0;
    dec.alu_op       = ALU_ADD;
    dec.ext_sel      = 1'b1;
    dec.wr_reg_d_src = 1'b1;
    dec.reg_dst      = DST_RT;
    case (op)
      OP_ADD:   begin dec.is_rtype = 1'b1; dec.reg_dst = DST_RD; end
      OP_SUB:   begin dec.is_rtype = 1'b1; dec.reg_dst = DST_RD; dec.alu_op = ALU_SUB; end
      OP_AND:   begin dec.is_rtype = 1'b1; dec.reg_dst = DST_RD; dec.alu_op = ALU_AND; end
      OP_OR:    begin dec.is_rtype = 1'b1; dec.reg_dst = DST_RD; dec.alu_op = ALU_OR; end
      OP_SLL:   begin
        dec.is_rtype  = 1'b1;
        dec.reg_dst   = DST_RD;
        dec.alu_op    = ALU_SLL;
        dec.alu_src_a = 1'b1;
      end
      OP_ADDIU: begin dec.is_imm = 1'b1; dec.alu_src_b = 1'b1; end
      // Logical immediates are zero-extended.
      OP_ANDI:  begin dec.is_imm = 1'b1; dec.alu_src_b = 1'b1; dec.alu_op = ALU_AND; dec.ext_sel = 1'b0; end
      OP_ORI:   begin dec.is_imm = 1'b1; dec.alu_src_b = 1'b1; dec.alu_op = ALU_OR;  dec.ext_sel = 1'b0; end
      OP_SLTI:  begin dec.is_imm = 1'b1; dec.alu_src_b = 1'b1; dec.alu_op = ALU_SLT; end
      OP_SW:    begin dec.is_sw = 1'b1; dec.alu_src_b = 1'b1; end
      OP_LW:    begin dec.is_lw = 1'b1; dec.alu_src_b = 1'b1; dec.db_data_src = 1'b1; end
      OP_BEQ:   begin dec.is_branch = 1'b1; dec.is_beq  = 1'b1; dec.alu_op = ALU_SUB; end
      OP_BNE:   begin dec.is_branch = 1'b1; dec.is_bne  = 1'b1; dec.alu_op = ALU_SUB; end
      OP_BLTZ:  begin dec.is_branch = 1'b1; dec.is_bltz = 1'b1; dec.alu_op = ALU_SUB; end
      OP_J:     dec.is_j = 1'b1;
      OP_JR:    dec.is_jr = 1'b1;
      OP_JAL:   begin dec.is_jal = 1'b1; dec.reg_dst = DST_RA; dec.wr_reg_d_src = 1'b0; end
      OP_HALT:  dec.is_halt = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle controller: IF/ID/EXE/MEM/WB/HALT sequencer, stage-gated
// enables, PC source selection and retired-instruction counter.
// Ports: CLK, Reset (sync, active-high), bus (master modport: OpCode/zero/sign
// in; enables, selects, State, Halted, InstrCount out).
module multicycle_control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input logic                       CLK,
  input logic                       Reset,
  multicycle_control_unit_if.master bus
);

  state_t           state;
  logic [CNT_W-1:0] instr_count;
  decode_t          dec;
  logic             is_nop;
  logic             last_cycle;
  logic             pc_wre;
  logic             taken;

  opcode_decoder u_decoder (
    .op  (bus.OpCode),
    .dec (dec)
  );

  assign is_nop = ~(dec.is_rtype | dec.is_imm | dec.is_lw | dec.is_sw | dec.is_branch |
                    dec.is_j | dec.is_jr | dec.is_jal | dec.is_halt);

  // zero/sign only matter in EXE because PC writes for branches occur only there.
  assign taken = (dec.is_beq & bus.zero) | (dec.is_bne & ~bus.zero) | (dec.is_bltz & bus.sign);

  // Final cycle of the current instruction (next state is IF).
  always_comb begin
    last_cycle = 1'b0;
    case (state)
      S_ID:    last_cycle = dec.is_j | dec.is_jr | dec.is_jal | is_nop;
      S_EXE:   last_cycle = dec.is_branch;
      S_MEM:   last_cycle = ~dec.is_lw;
      S_WB:    last_cycle = 1'b1;
      default: last_cycle = 1'b0;
    endcase
  end

  assign pc_wre = last_cycle & ~Reset;

  // State sequencer and retired-instruction counter.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= S_IF;
      instr_count <= '0;
    end else begin
      if (pc_wre) instr_count <= instr_count + CNT_W'(1);
      case (state)
        S_IF:  state <= S_ID;
        S_ID: begin
          if (dec.is_halt)     state <= S_HALT;
          else if (last_cycle) state <= S_IF;
          else                 state <= S_EXE;
        end
        S_EXE: begin
          if (last_cycle)                   state <= S_IF;
          else if (dec.is_lw | dec.is_sw)   state <= S_MEM;
          else                              state <= S_WB;
        end
        S_MEM:   state <= dec.is_lw ? S_WB : S_IF;
        S_WB:    state <= S_IF;
        S_HALT:  state <= S_HALT;
        default: state <= S_IF;
      endcase
    end
  end

  // PC source is only meaningful while the PC is being written.
  always_comb begin
    bus.PCSrc = PC_NEXT;
    if (pc_wre) begin
      if (dec.is_jr)                   bus.PCSrc = PC_JR;
      else if (dec.is_j | dec.is_jal)  bus.PCSrc = PC_JUMP;
      else if (dec.is_branch & taken)  bus.PCSrc = PC_BRANCH;
    end
  end

  assign bus.PCWre      = pc_wre;
  assign bus.IRWre      = ~Reset & (state == S_IF);
  assign bus.RegWre     = ~Reset & (((state == S_WB) & (dec.is_rtype | dec.is_imm | dec.is_lw)) |
                                    ((state == S_ID) & dec.is_jal));
  assign bus.RD         = ~(~Reset & (state == S_MEM) & dec.is_lw);
  assign bus.WR         = ~(~Reset & (state == S_MEM) & dec.is_sw);
  assign bus.InsMemRW   = 1'b1;
  assign bus.ALUOp      = dec.alu_op;
  assign bus.ALUSrcA    = dec.alu_src_a;
  assign bus.ALUSrcB    = dec.alu_src_b;
  assign bus.ExtSel     = dec.ext_sel;
  assign bus.RegDst     = dec.reg_dst;
  assign bus.DBDataSrc  = dec.db_data_src;
  assign bus.WrRegDSrc  = dec.wr_reg_d_src;
  assign bus.State      = state;
  assign bus.Halted     = (state == S_HALT);
  assign bus.InstrCount = instr_count;

endmodule
